// File: rtl/acs_survivor_unit.sv
// acs_survivor_unit
// Add-compare-select and survivor-decision store for a 4-state hard-decision
// Viterbi decoder (K=3, rate 1/2, G0=111, G1=101).
//
// Trellis state s = {s1,s0} holds the last two input bits, with s1 the newest.
// The next state is {u,s1}. For input u from state {s1,s0} the encoder emits
// G0 = u^s1^s0 and G1 = u^s0.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   i_valid      received symbol valid
//   i_sym[1:0]   received symbol, [1]=G0 bit, [0]=G1 bit
//   o_ready      symbol accepted when i_valid && o_ready
//   o_en_t       decision block complete, traceback enable
//   o_sel_node   state with the minimum metric at the end of the block
//   o_bck_prv_st decisions, bit [4k+s] = decision of state s at step k
//   i_tb_done    one-cycle pulse from traceback once the block is consumed
//   o_pm         path metrics, state s at [PM_W*s +: PM_W]
//
// Handshake: a symbol transfers on a rising edge where i_valid && o_ready.
// o_ready is low for the whole HANDOFF phase; the source must hold its symbol.
module acs_survivor_unit #(
  parameter int PM_W    = 6,
  parameter int TB_LEN  = 8,
  parameter int INIT_PM = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [1:0]            i_sym,
  output logic                  o_ready,
  output logic                  o_en_t,
  output logic [1:0]            o_sel_node,
  output logic [4*TB_LEN-1:0]   o_bck_prv_st,
  input  logic                  i_tb_done,
  output logic [4*PM_W-1:0]     o_pm
);

  localparam int CNT_W = (TB_LEN > 1) ? $clog2(TB_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_LEN - 1);
  localparam logic [PM_W:0]    PM_MAX   = {1'b0, {PM_W{1'b1}}};

  localparam logic [0:0] ST_FILL    = 1'b0;
  localparam logic [0:0] ST_HANDOFF = 1'b1;

  logic [0:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PM_W-1:0]  pm_q [4];

  logic             accept;

  // Per-state ACS intermediates, one PM_W+1 bit wide so the add cannot wrap.
  logic [1:0]       sv;
  logic [1:0]       p0;
  logic [1:0]       p1;
  logic [PM_W:0]    cand0  [4];
  logic [PM_W:0]    cand1  [4];
  logic [PM_W:0]    new_pm [4];
  logic [PM_W:0]    diff_pm[4];
  logic [PM_W-1:0]  norm_pm[4];
  logic [3:0]       dec;
  logic [PM_W:0]    min_01;
  logic [PM_W:0]    min_23;
  logic [PM_W:0]    min_all;
  logic [1:0]       best_node;

  // Hamming distance between the received symbol and the branch label for
  // input u leaving state from_st.
  function automatic logic [1:0] branch_metric(input logic [1:0] from_st,
                                               input logic       u,
                                               input logic [1:0] sym);
    logic       g0;
    logic       g1;
    logic [1:0] diff;
    g0   = u ^ from_st[1] ^ from_st[0];
    g1   = u ^ from_st[0];
    diff = sym ^ {g0, g1};
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  assign accept  = i_valid && (state_q == ST_FILL);
  assign o_ready = (state_q == ST_FILL);
  assign o_en_t  = (state_q == ST_HANDOFF);

  always_comb begin
    sv  = '0;
    p0  = '0;
    p1  = '0;
    dec = '0;
    for (int s = 0; s < 4; s++) begin
      sv = 2'(s);
      // Both predecessors of {a,b} share b as their newest bit; the input
      // that leads into {a,b} is a.
      p0 = {sv[0], 1'b0};
      p1 = {sv[0], 1'b1};
      cand0[s]  = {1'b0, pm_q[p0]} + {{(PM_W-1){1'b0}}, branch_metric(p0, sv[1], i_sym)};
      cand1[s]  = {1'b0, pm_q[p1]} + {{(PM_W-1){1'b0}}, branch_metric(p1, sv[1], i_sym)};
      // Strict compare: ties keep the even predecessor.
      dec[s]    = (cand1[s] < cand0[s]);
      new_pm[s] = dec[s] ? cand1[s] : cand0[s];
    end

    min_01  = (new_pm[1] < new_pm[0]) ? new_pm[1] : new_pm[0];
    min_23  = (new_pm[3] < new_pm[2]) ? new_pm[3] : new_pm[2];
    min_all = (min_23 < min_01) ? min_23 : min_01;

    for (int s = 0; s < 4; s++) begin
      diff_pm[s] = new_pm[s] - min_all;
      norm_pm[s] = (diff_pm[s] > PM_MAX) ? {PM_W{1'b1}} : diff_pm[s][PM_W-1:0];
    end

    // Lowest index holding the minimum; saturation never touches the minimum.
    if (new_pm[0] == min_all)      best_node = 2'd0;
    else if (new_pm[1] == min_all) best_node = 2'd1;
    else if (new_pm[2] == min_all) best_node = 2'd2;
    else                           best_node = 2'd3;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_FILL;
      cnt_q        <= '0;
      o_sel_node   <= '0;
      o_bck_prv_st <= '0;
      pm_q[0]      <= '0;
      pm_q[1]      <= PM_W'(INIT_PM);
      pm_q[2]      <= PM_W'(INIT_PM);
      pm_q[3]      <= PM_W'(INIT_PM);
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            for (int s = 0; s < 4; s++) begin
              pm_q[s] <= norm_pm[s];
            end
            o_bck_prv_st[4*cnt_q +: 4] <= dec;
            if (cnt_q == CNT_LAST) begin
              cnt_q      <= '0;
              o_sel_node <= best_node;
              state_q    <= ST_HANDOFF;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HANDOFF: begin
          // Decisions, end node and metrics are frozen until traceback is done.
          if (i_tb_done) begin
            state_q <= ST_FILL;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  always_comb begin
    o_pm = '0;
    for (int s = 0; s < 4; s++) begin
      o_pm[PM_W*s +: PM_W] = pm_q[s];
    end
  end

endmodule

// File: tb/tb_acs_survivor_unit.sv
module tb_acs_survivor_unit;

  localparam int PM_W    = 6;
  localparam int TB_LEN  = 8;
  localparam int INIT_PM = 8;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                i_valid = 1'b0;
  logic [1:0]          i_sym = 2'b00;
  logic                i_tb_done = 1'b0;
  logic                o_ready;
  logic                o_en_t;
  logic [1:0]          o_sel_node;
  logic [4*TB_LEN-1:0] o_bck_prv_st;
  logic [4*PM_W-1:0]   o_pm;

  always #5 clk = ~clk;

  acs_survivor_unit #(.PM_W(PM_W), .TB_LEN(TB_LEN), .INIT_PM(INIT_PM)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_sym        (i_sym),
    .o_ready      (o_ready),
    .o_en_t       (o_en_t),
    .o_sel_node   (o_sel_node),
    .o_bck_prv_st (o_bck_prv_st),
    .i_tb_done    (i_tb_done),
    .o_pm         (o_pm)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_pm [4];
  logic [3:0] m_dec [TB_LEN];
  int         m_cnt;
  bit         m_hand;
  logic [1:0] m_sel;

  function automatic int hamming(input logic [1:0] a, input logic [1:0] b);
    return int'(a[1] ^ b[1]) + int'(a[0] ^ b[0]);
  endfunction

  function automatic logic [1:0] enc_out(input int st, input int u);
    int s1;
    int s0;
    s1 = (st >> 1) & 1;
    s0 = st & 1;
    return {1'(u ^ s1 ^ s0), 1'(u ^ s0)};
  endfunction

  task automatic model_reset();
    m_pm[0] = 0;
    for (int s = 1; s < 4; s++) m_pm[s] = INIT_PM;
    for (int k = 0; k < TB_LEN; k++) m_dec[k] = 4'h0;
    m_cnt  = 0;
    m_hand = 0;
    m_sel  = 2'd0;
  endtask

  // Walk every trellis edge, keep the cheapest arrival per state; the first
  // arrival wins on ties, which is the even predecessor.
  task automatic model_accept(input logic [1:0] sym);
    int best [4];
    int bd   [4];
    int mn;
    int maxv;
    int ns;
    int c;
    maxv = (1 << PM_W) - 1;
    for (int s = 0; s < 4; s++) begin
      best[s] = 1 << 30;
      bd[s]   = 0;
    end
    for (int p = 0; p < 4; p++) begin
      for (int u = 0; u < 2; u++) begin
        ns = u * 2 + (p >> 1);
        c  = m_pm[p] + hamming(sym, enc_out(p, u));
        if (c < best[ns]) begin
          best[ns] = c;
          bd[ns]   = p & 1;
        end
      end
    end
    mn = best[0];
    for (int s = 1; s < 4; s++) if (best[s] < mn) mn = best[s];
    for (int s = 0; s < 4; s++) begin
      m_pm[s] = best[s] - mn;
      if (m_pm[s] > maxv) m_pm[s] = maxv;
      m_dec[m_cnt][s] = bd[s][0];
    end
    if (m_cnt == TB_LEN - 1) begin
      m_cnt  = 0;
      m_hand = 1;
      m_sel  = 2'd0;
      for (int s = 3; s >= 0; s--) if (m_pm[s] <= m_pm[m_sel]) m_sel = 2'(s);
    end else begin
      m_cnt++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else if (!m_hand) begin
        if (i_valid) model_accept(i_sym);
      end else if (i_tb_done) begin
        m_hand = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [4*PM_W-1:0]   exp_pm;
    logic [4*TB_LEN-1:0] exp_bck;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int s = 0; s < 4; s++) exp_pm[PM_W*s +: PM_W] = PM_W'(m_pm[s]);
        for (int k = 0; k < TB_LEN; k++) exp_bck[4*k +: 4] = m_dec[k];
        chk("cyc_ready", 64'(o_ready), 64'(!m_hand));
        chk("cyc_en_t", 64'(o_en_t), 64'(m_hand));
        chk("cyc_pm", 64'(o_pm), 64'(exp_pm));
        chk("cyc_bck", 64'(o_bck_prv_st), 64'(exp_bck));
        chk("cyc_sel", 64'(o_sel_node), 64'(m_sel));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] s);
    bit acc;
    int n;
    i_valid = 1'b1;
    i_sym   = s;
    acc     = 1'b0;
    n       = 0;
    while (!acc && n < 40) begin
      acc = o_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    i_valid   = 1'b0;
    i_tb_done = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_pm", 64'(o_pm), 64'({6'd8, 6'd8, 6'd8, 6'd0}));
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_en_t", 64'(o_en_t), 64'd0);
    chk("rst_sel", 64'(o_sel_node), 64'd0);
    chk("rst_bck", 64'(o_bck_prv_st), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic release_tb();
    i_valid   = 1'b0;
    i_tb_done = 1'b1;
    @(posedge clk);
    #1;
    i_tb_done = 1'b0;
    chk("release_en_t", 64'(o_en_t), 64'd0);
    chk("release_ready", 64'(o_ready), 64'd1);
  endtask

  function automatic logic [7:0] decode(input logic [4*TB_LEN-1:0] bck, input logic [1:0] sel);
    logic [1:0] s;
    logic [7:0] u;
    s = sel;
    u = '0;
    for (int k = TB_LEN - 1; k >= 0; k--) begin
      u[k] = s[1];
      s    = {s[0], bck[4*k + int'(s)]};
    end
    return u;
  endfunction

  // Message 1,0,1,1,0,0,0,0 from state 0.
  logic [1:0] msg_a [8] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
  // Message 0,1,1,0,1,0,0,0 from state 0.
  logic [1:0] msg_b [8] = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};

  initial begin
    #200000;
    chk("global_timeout", 64'd0, 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [7:0] st0_bits;

    // Test 1: all-zero block
    do_reset();
    send(2'b00);
    chk("t1_pm_step0", 64'(o_pm), 64'({6'd9, 6'd2, 6'd9, 6'd0}));
    for (int k = 1; k < TB_LEN; k++) send(2'b00);
    i_valid = 1'b0;
    chk("t1_en_t", 64'(o_en_t), 64'd1);
    chk("t1_ready", 64'(o_ready), 64'd0);
    chk("t1_sel", 64'(o_sel_node), 64'd0);
    chk("t1_pm0", 64'(o_pm[PM_W-1:0]), 64'd0);
    for (int k = 0; k < TB_LEN; k++) st0_bits[k] = o_bck_prv_st[4*k];
    chk("t1_state0_dec", 64'(st0_bits), 64'd0);
    release_tb();

    // Test 2: clean message, with a stray done pulse during FILL
    do_reset();
    for (int k = 0; k < TB_LEN; k++) begin
      i_tb_done = (k == 3);
      send(msg_a[k]);
      i_tb_done = 1'b0;
    end
    i_valid = 1'b0;
    chk("t2_en_t", 64'(o_en_t), 64'd1);
    chk("t2_sel", 64'(o_sel_node), 64'd0);
    chk("t2_pm0", 64'(o_pm[PM_W-1:0]), 64'd0);
    chk("t2_pm_others", 64'(o_pm[PM_W +: PM_W] != 0 && o_pm[2*PM_W +: PM_W] != 0 &&
                            o_pm[3*PM_W +: PM_W] != 0), 64'd1);
    chk("t2_decode", 64'(decode(o_bck_prv_st, o_sel_node)), 64'h0D);
    release_tb();

    // Test 3: one corrupted symbol
    do_reset();
    for (int k = 0; k < TB_LEN; k++) send((k == 2) ? 2'b01 : msg_a[k]);
    i_valid = 1'b0;
    chk("t3_sel", 64'(o_sel_node), 64'd0);
    chk("t3_decode", 64'(decode(o_bck_prv_st, o_sel_node)), 64'h0D);

    // Test 4: HANDOFF holds against new symbols, then next block
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1;
      i_sym   = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      chk("t4_hold_ready", 64'(o_ready), 64'd0);
      chk("t4_hold_en_t", 64'(o_en_t), 64'd1);
      chk("t4_hold_decode", 64'(decode(o_bck_prv_st, o_sel_node)), 64'h0D);
    end
    release_tb();
    for (int k = 0; k < TB_LEN; k++) send(msg_b[k]);
    i_valid = 1'b0;
    chk("t4_en_t", 64'(o_en_t), 64'd1);
    chk("t4_sel", 64'(o_sel_node), 64'd0);
    chk("t4_decode", 64'(decode(o_bck_prv_st, o_sel_node)), 64'h16);
    release_tb();

    // Test 5: reset mid-block, then a fresh block
    for (int k = 0; k < 4; k++) send(msg_a[k]);
    do_reset();
    for (int k = 0; k < TB_LEN; k++) send(msg_a[k]);
    i_valid = 1'b0;
    chk("t5_en_t", 64'(o_en_t), 64'd1);
    chk("t5_sel", 64'(o_sel_node), 64'd0);
    chk("t5_decode", 64'(decode(o_bck_prv_st, o_sel_node)), 64'h0D);
    release_tb();

    // Test 6: all-ones stream exercising decision ties
    do_reset();
    send(2'b11);
    chk("t6_pm_step0", 64'(o_pm), 64'({6'd9, 6'd0, 6'd9, 6'd2}));
    chk("t6_dec_step0", 64'(o_bck_prv_st[3:0]), 64'd0);
    for (int k = 1; k < TB_LEN; k++) send(2'b11);
    i_valid = 1'b0;
    chk("t6_en_t", 64'(o_en_t), 64'd1);
    chk("t6_sel_model", 64'(o_sel_node), 64'(m_sel));
    release_tb();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
